// File: rtl/sub_share_arb.sv
// Round-robin arbiter sharing one WIDTH-bit subtractor among NREQ requesters with lock/hold.
// Optional lock timeout: define SUB_ARB_LOCK_TIMEOUT_EN to bound locked grants to LOCK_MAX cycles.
module sub_share_arb #(
  parameter int NREQ     = 3,
  parameter int WIDTH    = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ-1:0]       Lock,
  input  logic [NREQ*WIDTH-1:0] Op_A,
  input  logic [NREQ*WIDTH-1:0] Op_B,
  input  logic [WIDTH-1:0]      Sub_Result,
  output logic [WIDTH-1:0]      Sub_A,
  output logic [WIDTH-1:0]      Sub_B,
  output logic [NREQ-1:0]       Gnt,
  output logic [WIDTH-1:0]      Result,
  output logic                  Result_Valid,
  output logic                  Lock_Err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || LOCK_MAX < 1) begin : g_bad_param
    $error("sub_share_arb: NREQ must be 2..8 and LOCK_MAX >= 1");
  end

  logic [NREQ-1:0]  r_gnt;
  logic [PW-1:0]    r_ptr;
  logic [NREQ-1:0]  w_gnt_next;
  logic [PW-1:0]    w_ptr_next;
  logic [NREQ-1:0]  w_req_eff;
  logic [NREQ-1:0]  w_req_others;
  logic             w_hold;
  logic             w_force;
  logic             w_found;
  logic [PW:0]      w_sum;
  logic [PW-1:0]    w_idx;
  logic [WIDTH-1:0] w_sub_a;
  logic [WIDTH-1:0] w_sub_b;

  assign w_hold       = |(r_gnt & Req & Lock);
  assign w_req_others = Req & ~r_gnt;

`ifdef SUB_ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] r_lock_cnt;
  logic          r_lock_err;

  assign w_force = w_hold && (r_lock_cnt == CW'(LOCK_MAX));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_lock_cnt <= '0;
      r_lock_err <= 1'b0;
    end else begin
      r_lock_err <= w_force;
      if (w_hold && !w_force) begin
        if (r_lock_cnt != CW'(LOCK_MAX))
          r_lock_cnt <= r_lock_cnt + CW'(1);
      end else if (|w_gnt_next) begin
        r_lock_cnt <= CW'(1);
      end else begin
        r_lock_cnt <= '0;
      end
    end
  end

  assign Lock_Err = r_lock_err;
`else
  assign w_force  = 1'b0;
  assign Lock_Err = 1'b0;
`endif

  // A forced release skips the current grantee unless nobody else is asking.
  assign w_req_eff = (w_force && |w_req_others) ? w_req_others : Req;

  always_comb begin
    w_gnt_next = '0;
    w_ptr_next = r_ptr;
    w_found    = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    if (w_hold && !w_force) begin
      w_gnt_next = r_gnt;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        w_sum = {1'b0, r_ptr} + (PW+1)'(i);
        if (w_sum >= (PW+1)'(NREQ))
          w_sum = w_sum - (PW+1)'(NREQ);
        w_idx = w_sum[PW-1:0];
        if (!w_found && w_req_eff[w_idx]) begin
          w_found           = 1'b1;
          w_gnt_next[w_idx] = 1'b1;
          w_ptr_next        = (w_sum == (PW+1)'(NREQ - 1)) ? '0 : PW'(w_sum + (PW+1)'(1));
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_gnt <= '0;
      r_ptr <= '0;
    end else begin
      r_gnt <= w_gnt_next;
      r_ptr <= w_ptr_next;
    end
  end

  always_comb begin
    w_sub_a = '0;
    w_sub_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) begin
        w_sub_a = w_sub_a | Op_A[i*WIDTH +: WIDTH];
        w_sub_b = w_sub_b | Op_B[i*WIDTH +: WIDTH];
      end
    end
  end

  assign Gnt          = r_gnt;
  assign Sub_A        = w_sub_a;
  assign Sub_B        = w_sub_b;
  assign Result_Valid = |r_gnt;
  assign Result       = Result_Valid ? Sub_Result : '0;

  a_gnt_onehot0: assert property (@(posedge Clk) disable iff (Reset) $onehot0(r_gnt));

endmodule

// File: tb/tb_sub_share_arb.sv
// Directed bench for sub_share_arb (NREQ=3, WIDTH=32, LOCK_MAX=4).
module tb_sub_share_arb;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  Req;
  logic [2:0]  Lock;
  logic [95:0] Op_A;
  logic [95:0] Op_B;
  logic [31:0] Sub_Result;
  logic [31:0] Sub_A;
  logic [31:0] Sub_B;
  logic [2:0]  Gnt;
  logic [31:0] Result;
  logic        Result_Valid;
  logic        Lock_Err;

  int total = 0;
  int bad   = 0;

  sub_share_arb #(.NREQ(3), .WIDTH(32), .LOCK_MAX(4)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Lock(Lock), .Op_A(Op_A), .Op_B(Op_B),
    .Sub_Result(Sub_Result), .Sub_A(Sub_A), .Sub_B(Sub_B), .Gnt(Gnt),
    .Result(Result), .Result_Valid(Result_Valid), .Lock_Err(Lock_Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset      = 1'b1;
    Req        = 3'b000;
    Lock       = 3'b000;
    Op_A       = {32'd300, 32'd100, 32'd50};
    Op_B       = {32'd30,  32'd7,   32'd5};
    Sub_Result = 32'd93;
    #2;
    chk("rst_gnt",   32'(Gnt), 32'd0);
    chk("rst_suba",  Sub_A, 32'd0);
    chk("rst_subb",  Sub_B, 32'd0);
    chk("rst_res",   Result, 32'd0);
    chk("rst_valid", 32'(Result_Valid), 32'd0);
    chk("rst_lerr",  32'(Lock_Err), 32'd0);

    // round robin with everyone requesting
    @(negedge Clk);
    Reset = 1'b0;
    Req   = 3'b111;
    tick();
    chk("rr1_gnt",   32'(Gnt), 32'b001);
    chk("rr1_valid", 32'(Result_Valid), 32'd1);
    chk("rr1_suba",  Sub_A, 32'd50);
    chk("rr1_subb",  Sub_B, 32'd5);
    tick();
    chk("rr2_gnt",   32'(Gnt), 32'b010);
    chk("dp_suba",   Sub_A, 32'd100);
    chk("dp_subb",   Sub_B, 32'd7);
    chk("dp_res",    Result, 32'd93);
    chk("dp_valid",  32'(Result_Valid), 32'd1);
    tick();
    chk("rr3_gnt",   32'(Gnt), 32'b100);
    chk("rr3_suba",  Sub_A, 32'd300);
    tick();
    chk("rr4_gnt",   32'(Gnt), 32'b001);
    chk("rr4_valid", 32'(Result_Valid), 32'd1);

    // idle: no grant, datapath zeroed, pointer kept at 1
    Req = 3'b000;
    tick();
    chk("idle_gnt",   32'(Gnt), 32'd0);
    chk("idle_suba",  Sub_A, 32'd0);
    chk("idle_subb",  Sub_B, 32'd0);
    chk("idle_res",   Result, 32'd0);
    chk("idle_valid", 32'(Result_Valid), 32'd0);
    Req = 3'b111;
    tick();
    chk("ptr_kept_gnt", 32'(Gnt), 32'b010);

`ifdef SUB_ARB_LOCK_TIMEOUT_EN
    // lock timeout: 2 locked with 0 also requesting
    Req  = 3'b101;
    Lock = 3'b100;
    tick();
    chk("to_c1_gnt", 32'(Gnt), 32'b100);
    chk("to_c1_err", 32'(Lock_Err), 32'd0);
    tick();
    chk("to_c2_gnt", 32'(Gnt), 32'b100);
    tick();
    chk("to_c3_gnt", 32'(Gnt), 32'b100);
    tick();
    chk("to_c4_gnt", 32'(Gnt), 32'b100);
    chk("to_c4_err", 32'(Lock_Err), 32'd0);
    tick();
    chk("to_rel_gnt", 32'(Gnt), 32'b001);
    chk("to_rel_err", 32'(Lock_Err), 32'd1);
    tick();
    chk("to_next_gnt", 32'(Gnt), 32'b100);
    chk("to_next_err", 32'(Lock_Err), 32'd0);
    // sole locked requester is re-granted on timeout
    Req = 3'b100;
    tick();
    chk("sole_c2_gnt", 32'(Gnt), 32'b100);
    tick();
    tick();
    chk("sole_c4_gnt", 32'(Gnt), 32'b100);
    chk("sole_c4_err", 32'(Lock_Err), 32'd0);
    tick();
    chk("sole_rel_gnt", 32'(Gnt), 32'b100);
    chk("sole_rel_err", 32'(Lock_Err), 32'd1);
    tick();
    chk("sole_after_gnt", 32'(Gnt), 32'b100);
    chk("sole_after_err", 32'(Lock_Err), 32'd0);
`else
    // lock held six cycles on requester 1, no timeout
    Req = 3'b011;
    tick();
    chk("lk_pre1_gnt", 32'(Gnt), 32'b001);
    tick();
    chk("lk_c1_gnt", 32'(Gnt), 32'b010);
    Lock = 3'b010;
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk($sformatf("lk_c%0d_gnt", c), 32'(Gnt), 32'b010);
      chk($sformatf("lk_c%0d_err", c), 32'(Lock_Err), 32'd0);
    end
    Lock = 3'b000;
    tick();
    chk("lk_drop_gnt", 32'(Gnt), 32'b001);
    // lock on a non-granted requester is ignored
    Req  = 3'b111;
    Lock = 3'b100;
    tick();
    chk("lkign_gnt", 32'(Gnt), 32'b010);
    tick();
    chk("lk2_c1_gnt", 32'(Gnt), 32'b100);
    tick();
    chk("lk2_c2_gnt", 32'(Gnt), 32'b100);
`endif

    // grantee drops Req while Lock stays high
    Req  = 3'b011;
    Lock = 3'b100;
    tick();
    chk("dropreq_gnt", 32'(Gnt), 32'b001);

    // async reset in the middle of a locked grant
    Req = 3'b111;
    tick();
    chk("pre_rst1_gnt", 32'(Gnt), 32'b010);
    tick();
    chk("pre_rst2_gnt", 32'(Gnt), 32'b100);
    tick();
    chk("pre_rst3_gnt", 32'(Gnt), 32'b100);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_gnt",   32'(Gnt), 32'd0);
    chk("arst_valid", 32'(Result_Valid), 32'd0);
    chk("arst_suba",  Sub_A, 32'd0);
    chk("arst_res",   Result, 32'd0);
    tick();
    chk("arst_hold_gnt", 32'(Gnt), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(Gnt), 32'b001);
    chk("post_rst_err", 32'(Lock_Err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
